// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA pack gearbox.
//   pack_state_e  : packer FSM states
//   in_bytes_of   : bytes per DMA beat for a given beat width
//   out_bytes_of  : bytes per buffer word for a given word width
//   byte_mask     : n bytes -> bit mask (low n*8 bits set); callers size-cast to their width
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pack_state_e;

  // Widest beat the mask helper can cover.
  localparam int unsigned MaskW = 1024;

  function automatic int unsigned in_bytes_of(int unsigned in_w);
    return in_w / 8;
  endfunction

  function automatic int unsigned out_bytes_of(int unsigned out_w);
    return out_w / 8;
  endfunction

  function automatic logic [MaskW-1:0] byte_mask(int unsigned n);
    logic [MaskW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaskW / 8; i++) begin
      if (i < n) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/dma_pack_gearbox_if.sv
// Beat-in / word-out handshake bundle of the pack gearbox.
//   in_*  : DMA beat stream (valid/ready, data, last, byte count of last beat)
//   out_* : buffer word stream (valid/ready, address, data, last)
// Modports: master = DMA source + buffer sink side, slave = the packer.
interface dma_pack_gearbox_if #(
  parameter int unsigned IN_W    = 64,
  parameter int unsigned OUT_W   = 112,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned BYTES_W = $clog2(IN_W / 8) + 1
);

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic               in_last;
  logic [BYTES_W-1:0] in_bytes;

  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_addr;
  logic [OUT_W-1:0]   out_data;
  logic               out_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_last
  );

endinterface

// File: rtl/dma_pack_acc.sv
// Byte accumulator of the pack gearbox: OB+IB bytes wide, byte 0 at bits [7:0].
// Each cycle it optionally drops the low min(fill,OB) bytes (load) and then writes
// a beat at offset fill (accept). Bytes at or above fill are always zero, so a
// partially filled low word is already zero-padded.
//   clk, rst  : clock, async active-high reset
//   clear     : synchronous clear (transfer start)
//   load      : low OB bytes are being taken this cycle
//   accept    : a beat is being written this cycle
//   in_data   : beat data
//   nbytes    : valid bytes in this beat
//   fill      : current byte count
//   fill_sh   : byte count after this cycle's shift, before the insert
//   word      : low OB bytes of the accumulator
module dma_pack_acc
  import dma_pkg::*;
#(
  parameter int unsigned IN_W    = 64,
  parameter int unsigned OUT_W   = 112,
  parameter int unsigned FILL_W  = $clog2(IN_W / 8 + OUT_W / 8 + 1),
  parameter int unsigned BYTES_W = $clog2(IN_W / 8) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               accept,
  input  logic [IN_W-1:0]    in_data,
  input  logic [BYTES_W-1:0] nbytes,
  output logic [FILL_W-1:0]  fill,
  output logic [FILL_W-1:0]  fill_sh,
  output logic [OUT_W-1:0]   word
);

  localparam int unsigned IB    = in_bytes_of(IN_W);
  localparam int unsigned OB    = out_bytes_of(OUT_W);
  localparam int unsigned ACC_W = (IB + OB) * 8;
  localparam logic [FILL_W-1:0] OB_F = FILL_W'(OB);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_sh, ins;
  logic [FILL_W-1:0] fill_q, fill_d, shamt;
  logic [IN_W-1:0]   beat;

  assign shamt   = !load ? '0 : ((fill_q >= OB_F) ? OB_F : fill_q);
  assign fill_sh = fill_q - shamt;
  assign acc_sh  = acc_q >> {shamt, 3'b000};

  // Zero the unused tail of a short last beat to keep the zero-above-fill invariant.
  assign beat = in_data & IN_W'(byte_mask(32'(nbytes)));
  assign ins  = ACC_W'(beat) << {fill_sh, 3'b000};

  always_comb begin
    acc_d  = acc_sh;
    fill_d = fill_sh;
    if (accept) begin
      acc_d  = acc_sh | ins;
      fill_d = fill_sh + FILL_W'(nbytes);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else if (clear) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;
  assign word = acc_q[OUT_W-1:0];

endmodule

// File: rtl/dma_pack_gearbox.sv
// Packs IN_W-bit DMA beats into OUT_W-bit buffer words, carrying residue bytes
// across words, with valid/ready on both sides, zero-padded flush of the last
// word and a wrapping buffer address starting at cfg_base.
//   clk, rst  : clock, async active-high reset
//   start     : pulse; aborts any transfer, clears state, loads cfg_base
//   cfg_base  : first buffer address of the transfer
//   bus       : beat input and word output handshakes (slave modport)
//   busy      : transfer in progress
//   err       : sticky, an illegal in_bytes was seen on a last beat
module dma_pack_gearbox
  import dma_pkg::*;
#(
  parameter int unsigned IN_W   = 64,
  parameter int unsigned OUT_W  = 112,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_base,
  dma_pack_gearbox_if.slave   bus,
  output logic                busy,
  output logic                err
);

  localparam int unsigned IB      = in_bytes_of(IN_W);
  localparam int unsigned OB      = out_bytes_of(OUT_W);
  localparam int unsigned FILL_W  = $clog2(OB + IB + 1);
  localparam int unsigned BYTES_W = $clog2(IB) + 1;
  localparam logic [FILL_W-1:0]  OB_F      = FILL_W'(OB);
  localparam logic [BYTES_W-1:0] IB_B      = BYTES_W'(IB);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(DEPTH - 1);

  pack_state_e state_q, state_d;

  logic [FILL_W-1:0]  fill, fill_sh;
  logic [OUT_W-1:0]   word;
  logic [BYTES_W-1:0] nbytes;
  logic               flushing, slot_free, load, last_word;
  logic               in_ready, accept, bytes_ok;

  logic               out_valid_q, out_last_q, err_q;
  logic [OUT_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]  out_addr_q, addr_q;

  assign flushing  = (state_q == FLUSH);
  assign slot_free = !out_valid_q || bus.out_ready;
  assign load      = (state_q != IDLE) && !start && slot_free &&
                     ((fill >= OB_F) || (flushing && (fill != '0)));
  // In FLUSH nothing more arrives, so a load that empties the accumulator is final.
  assign last_word = flushing && (fill <= OB_F);

  // Post-shift fill below OB is the same as "fill<OB or load" whenever IB<=OB, and
  // also keeps the accumulator bounded when a beat is wider than a word.
  assign in_ready = (state_q == RUN) && !start && (fill_sh < OB_F);
  assign accept   = bus.in_valid && in_ready;

  // Illegal last-beat counts are taken as a full beat.
  assign bytes_ok = (bus.in_bytes != '0) && (bus.in_bytes <= IB_B);
  assign nbytes   = (bus.in_last && bytes_ok) ? bus.in_bytes : IB_B;

  dma_pack_acc #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .FILL_W  (FILL_W),
    .BYTES_W (BYTES_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .load    (load),
    .accept  (accept),
    .in_data (bus.in_data),
    .nbytes  (nbytes),
    .fill    (fill),
    .fill_sh (fill_sh),
    .word    (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && bus.in_last) state_d = FLUSH;
      FLUSH:   if ((fill == '0) && out_valid_q && out_last_q && bus.out_ready) state_d = IDLE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
    end else if (start) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      addr_q      <= cfg_base;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_last_q  <= last_word;
        out_data_q  <= word;
        out_addr_q  <= addr_q;
        // Every loaded word is eventually written, so advancing here numbers words
        // exactly as advancing on the sink handshake would.
        addr_q      <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (accept && bus.in_last && !bytes_ok) err_q <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

endmodule

// File: doc/dma_pack_gearbox.md
Name: dma_pack_gearbox

Overview:
- Generalised successor to the fixed 64->112 DMA packer.
- Packs IN_W-bit DMA beats into OUT_W-bit buffer words for any byte-multiple widths, carrying residue bytes across words so no bytes are dropped.
- Adds valid/ready backpressure on both sides, last-beat byte counts, zero-padded flush, a programmable base address and address wrap at DEPTH.
- Sits between act_dma/bsr_dma and act_buffer/wgt_buffer.

Parameters:
- IN_W, 64, DMA beat width in bits; multiple of 8.
- OUT_W, 112, buffer word width in bits; multiple of 8; any ratio to IN_W.
- DEPTH, 128, buffer depth in words.
- ADDR_W, $clog2(DEPTH), buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  pulse: clear packer state and load cfg_base.
- cfg_base  in  ADDR_W  first buffer address of a transfer.
- in_valid  in  1  DMA beat valid.
- in_ready  out  1  packer accepts beat.
- in_data  in  IN_W  beat data; byte 0 in bits [7:0].
- in_last  in  1  final beat of transfer.
- in_bytes  in  $clog2(IN_W/8)+1  valid bytes in last beat (1..IN_W/8); ignored when in_last=0.
- out_valid  out  1  buffer word valid (buf_we = out_valid & out_ready).
- out_ready  in  1  buffer accepts word.
- out_addr  out  ADDR_W  buffer write address.
- out_data  out  OUT_W  packed word; byte 0 in bits [7:0].
- out_last  out  1  final word of transfer.
- busy  out  1  transfer in progress.
- err  out  1  sticky: illegal in_bytes seen; cleared by start or rst.

Behaviour:
- IB = IN_W/8 and OB = OUT_W/8. The accumulator is OB+IB bytes wide; fill holds its byte count.
- Reset values: fill=0, out_valid=0, out_last=0, out_data=0, out_addr=0, busy=0, err=0, flushing=0.
- Load condition: when (fill>=OB or (flushing and fill>0)) and the output slot is free, the lower OB accumulator bytes move to the output register. The slot is free when !out_valid or out_ready. Unfilled bytes of a flushed word are zero. The accumulator then shifts down and fill decreases by min(fill,OB).
- in_ready = busy & !flushing & !start & (fill<OB or a load occurs this cycle). This is a combinational path from out_ready; no other comb paths.
- Accept (in_valid & in_ready): the beat bytes are written at the accumulator position fill, after any same-cycle shift, and fill increases by IB, or by in_bytes if in_last=1.
- Latency: a word becomes valid 1 cycle after the accept that completes it. With a continuously ready sink there are no bubbles; sustained rate is 1 beat/cycle.
- States:
  - IDLE: busy=0, in_ready=0.
  - RUN: entered on start; busy=1.
  - FLUSH: entered on accept with in_last=1; no input accepted.
  - FLUSH -> IDLE when fill=0 and the final word is accepted by the sink.
- out_last=1 only on the final word. If fill is a multiple of OB when in_last arrives, the word completed by that beat is final and no padding word is emitted.
- Address:
  - On start, the next write address is cfg_base.
  - Each out_valid & out_ready advances it by 1; DEPTH-1 wraps to 0.
  - out_addr is registered with out_data.
- Illegal in_bytes (0 or >IB) on a last beat: set err and treat the beat as IB bytes.
- start in any state aborts the current transfer: fill=0, out_valid=0, err=0, address reloaded, state RUN. A beat presented in the start cycle is not accepted.
- rst mid-transfer: all state returns to reset values immediately; partial data is discarded.
- in_valid while IDLE: ignored, in_ready stays 0.

Decomposition:
- Package dma_pkg holds:
  - IB/OB byte-count functions.
  - The pack_state_e enum {IDLE, RUN, FLUSH}.
  - A byte-mask helper (n bytes -> IN_W-bit mask).
- One sub-module, dma_pack_acc: the byte accumulator with insert-at-offset and shift-down. The top module keeps the FSM, the handshakes and the address counter.

Test Plan:
- Full beats: IN_W=64, OUT_W=112, base=0, 7 beats carrying bytes 0x00..0x37 with the last beat in_bytes=8, sink always ready -> 4 words. Word k holds bytes 14k..14k+13 at addresses 0..3; out_last on word 3 only; no padding word.
- Partial last: 3 beats, last beat in_bytes=5 (21 bytes) -> word0 = bytes 0..13; word1 = bytes 14..20 plus 7 zero bytes, with out_last=1; busy then falls.
- Backpressure: hold out_ready=0 for 10 cycles mid-stream -> in_ready drops once fill>=OB; no byte is lost or duplicated and the word order is intact after release.
- Wrap: DEPTH=128, base=126, 56 bytes -> addresses 126, 127, 0, 1.
- Abort and reset: start asserted after 2 beats -> no word is emitted and a new stream is packed from cfg_base. rst pulsed mid-stream -> out_valid=0, busy=0, fill=0 in the same cycle.
- Error: last beat with in_bytes=0 -> err=1, 8 bytes consumed; the next start clears err.
